// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - operand/hazard bundle between the ID/EX stage and the forwarding unit.
// Optional perf-counter signals exist only when FWD_HAZARD_PERF_CNT_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  logic [NUM_SRC*AW-1:0]    id_ra;
  logic [NUM_SRC-1:0]       id_re;
  logic [NUM_SRC*AW-1:0]    ex_ra;
  logic [AW-1:0]            ex_wa;
  logic                     ex_we;
  logic                     ex_is_load;
  logic [NUM_STAGES*AW-1:0] stage_wa;
  logic [NUM_STAGES-1:0]    stage_we;
  logic                     mem_is_load;
  logic                     mem_ready;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic                     bubble;
  logic                     freeze;
`ifdef FWD_HAZARD_PERF_CNT_EN
  logic [31:0]              stall_cycles;
  logic [31:0]              freeze_cycles;

  modport master (
    output id_ra, id_re, ex_ra, ex_wa, ex_we, ex_is_load,
    output stage_wa, stage_we, mem_is_load, mem_ready,
    input  fwd_sel, stall, bubble, freeze, stall_cycles, freeze_cycles
  );
  modport slave (
    input  id_ra, id_re, ex_ra, ex_wa, ex_we, ex_is_load,
    input  stage_wa, stage_we, mem_is_load, mem_ready,
    output fwd_sel, stall, bubble, freeze, stall_cycles, freeze_cycles
  );
`else
  modport master (
    output id_ra, id_re, ex_ra, ex_wa, ex_we, ex_is_load,
    output stage_wa, stage_we, mem_is_load, mem_ready,
    input  fwd_sel, stall, bubble, freeze
  );
  modport slave (
    input  id_ra, id_re, ex_ra, ex_wa, ex_we, ex_is_load,
    input  stage_wa, stage_we, mem_is_load, mem_ready,
    output fwd_sel, stall, bubble, freeze
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, load-use stall FSM and memory-wait freeze.
// Define FWD_HAZARD_PERF_CNT_EN to add saturating stall/freeze cycle counters.
module fwd_hazard_unit #(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  fwd_hazard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [2:0]               r_cnt;
  logic [2:0]               w_next_cnt;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_hz;
  logic                     w_freeze;
  logic                     w_stall;
  logic                     w_bubble;

  // Walk farthest to nearest so the nearest matching stage overwrites the select last.
  always_comb begin
    w_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (bus.stage_we[k-1] &&
            (bus.stage_wa[(k-1)*AW +: AW] == bus.ex_ra[i*AW +: AW]) &&
            (bus.ex_ra[i*AW +: AW] != '0)) begin
          w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    w_hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_re[i] && (bus.id_ra[i*AW +: AW] == bus.ex_wa)) w_hz = 1'b1;
    end
    w_hz = w_hz & bus.ex_we & bus.ex_is_load & (bus.ex_wa != '0);
  end

  assign w_freeze = bus.mem_is_load & ~bus.mem_ready & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // A frozen pipeline must not consume stall cycles, so state and count hold.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (!w_freeze) begin
      case (r_state)
        RUN: begin
          if (w_hz && (LOAD_LAT > 1)) begin
            w_next_state = LU_STALL;
            w_next_cnt   = 3'(LOAD_LAT - 1);
          end
        end
        LU_STALL: begin
          w_next_cnt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_next_state = RUN;
        end
        default: begin
          w_next_state = RUN;
          w_next_cnt   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    if (RST) begin
      w_stall  = 1'b0;
      w_bubble = 1'b0;
    end else if (w_freeze) begin
      w_stall  = 1'b1;
      w_bubble = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          w_stall  = w_hz;
          w_bubble = w_hz;
        end
        LU_STALL: begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
        default: begin
          w_stall  = 1'b0;
          w_bubble = 1'b0;
        end
      endcase
    end
  end

  assign bus.fwd_sel = w_fwd_sel;
  assign bus.stall   = w_stall;
  assign bus.bubble  = w_bubble;
  assign bus.freeze  = w_freeze;

`ifdef FWD_HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_freeze_cycles;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cycles  <= 32'd0;
      r_freeze_cycles <= 32'd0;
    end else begin
      if (w_bubble && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_freeze && (r_freeze_cycles != 32'hFFFF_FFFF)) r_freeze_cycles <= r_freeze_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.freeze_cycles = r_freeze_cycles;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed checks of forwarding, load-use stall, freeze and reset.
module tb_fwd_hazard_unit;
  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;
  int   bcount;

  fwd_hazard_unit_if #(.AW(5), .NUM_SRC(2), .NUM_STAGES(2)) bus1 ();
  fwd_hazard_unit_if #(.AW(5), .NUM_SRC(2), .NUM_STAGES(2)) bus3 ();

  fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .NUM_STAGES(2), .LOAD_LAT(1)) u_lat1 (
    .CLK(CLK), .RST(RST), .bus(bus1)
  );
  fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .NUM_STAGES(2), .LOAD_LAT(3)) u_lat3 (
    .CLK(CLK), .RST(RST), .bus(bus3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle1();
    bus1.id_ra = '0; bus1.id_re = '0; bus1.ex_ra = '0; bus1.ex_wa = '0;
    bus1.ex_we = 1'b0; bus1.ex_is_load = 1'b0; bus1.stage_wa = '0; bus1.stage_we = '0;
    bus1.mem_is_load = 1'b0; bus1.mem_ready = 1'b1;
  endtask

  task automatic idle3();
    bus3.id_ra = '0; bus3.id_re = '0; bus3.ex_ra = '0; bus3.ex_wa = '0;
    bus3.ex_we = 1'b0; bus3.ex_is_load = 1'b0; bus3.stage_wa = '0; bus3.stage_we = '0;
    bus3.mem_is_load = 1'b0; bus3.mem_ready = 1'b1;
  endtask

  // Load to r3 in EX, consumer in ID reads r3 on operand 1.
  task automatic hazard3();
    bus3.ex_wa = 5'd3; bus3.ex_we = 1'b1; bus3.ex_is_load = 1'b1;
    bus3.id_ra = {5'd3, 5'd0}; bus3.id_re = 2'b10;
  endtask

  task automatic clear_ex3();
    bus3.ex_we = 1'b0; bus3.ex_is_load = 1'b0; bus3.ex_wa = '0;
    bus3.id_ra = '0; bus3.id_re = '0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b1;
    idle1();
    idle3();
    cyc();
    // Hazard and memory wait both present while in reset: everything must stay quiet.
    hazard3();
    bus3.mem_is_load = 1'b1; bus3.mem_ready = 1'b0;
    #1;
    chk("rst_stall", 32'(bus3.stall), 32'd0);
    chk("rst_bubble", 32'(bus3.bubble), 32'd0);
    chk("rst_freeze", 32'(bus3.freeze), 32'd0);
    chk("rst_cnt", 32'(u_lat3.r_cnt), 32'd0);
    idle3();
    cyc();
    RST = 1'b0;
    cyc();

    // Forwarding selects.
    bus1.ex_ra = {5'd0, 5'd5}; bus1.stage_wa = {5'd5, 5'd5}; bus1.stage_we = 2'b11;
    #1 chk("fwd_nearest", 32'(bus1.fwd_sel), 32'h1);
    bus1.stage_we = 2'b10;
    #1 chk("fwd_stage2", 32'(bus1.fwd_sel), 32'h2);
    bus1.ex_ra = {5'd0, 5'd0}; bus1.stage_wa = {5'd0, 5'd0}; bus1.stage_we = 2'b11;
    #1 chk("fwd_r0", 32'(bus1.fwd_sel), 32'h0);
    bus1.ex_ra = {5'd7, 5'd3}; bus1.stage_wa = {5'd7, 5'd3}; bus1.stage_we = 2'b11;
    #1 chk("fwd_two_ops", 32'(bus1.fwd_sel), 32'h9);
    bus1.stage_we = 2'b00;
    #1 chk("fwd_no_we", 32'(bus1.fwd_sel), 32'h0);
    idle1();

    // LOAD_LAT=1 hazard: exactly one stall cycle.
    bus1.ex_wa = 5'd3; bus1.ex_we = 1'b1; bus1.ex_is_load = 1'b1;
    bus1.id_ra = {5'd3, 5'd0}; bus1.id_re = 2'b10;
    #1;
    chk("l1_stall", 32'(bus1.stall), 32'd1);
    chk("l1_bubble", 32'(bus1.bubble), 32'd1);
    cyc();
    bus1.ex_we = 1'b0; bus1.ex_is_load = 1'b0; bus1.ex_wa = '0;
    #1;
    chk("l1_after", 32'(bus1.stall), 32'd0);
    bus1.ex_wa = 5'd3; bus1.ex_we = 1'b1; bus1.ex_is_load = 1'b1; bus1.id_re = 2'b00;
    #1 chk("l1_no_re", 32'(bus1.stall), 32'd0);
    bus1.ex_wa = 5'd0; bus1.id_ra = {5'd0, 5'd0}; bus1.id_re = 2'b11;
    #1 chk("l1_wa_zero", 32'(bus1.stall), 32'd0);
    idle1();
    cyc();

    // LOAD_LAT=3 hazard: three stall cycles then back to RUN.
    hazard3();
    #1 chk("l3_c1", 32'({bus3.stall, bus3.bubble}), 32'd3);
    cyc();
    clear_ex3();
    #1;
    chk("l3_c2", 32'({bus3.stall, bus3.bubble}), 32'd3);
    chk("l3_cnt2", 32'(u_lat3.r_cnt), 32'd2);
    cyc();
    #1;
    chk("l3_c3", 32'({bus3.stall, bus3.bubble}), 32'd3);
    chk("l3_cnt1", 32'(u_lat3.r_cnt), 32'd1);
    cyc();
    #1;
    chk("l3_done", 32'({bus3.stall, bus3.bubble}), 32'd0);
    chk("l3_cnt0", 32'(u_lat3.r_cnt), 32'd0);

    // Clear counters, then LOAD_LAT=3 hazard with a 2-cycle freeze from stall cycle 2.
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    bcount = 0;
    hazard3();
    #1;
    chk("fz_c1", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd3);
    bcount += int'(bus3.bubble);
    cyc();
    clear_ex3();
    bus3.mem_is_load = 1'b1; bus3.mem_ready = 1'b0;
    #1;
    chk("fz_f1", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd6);
    bcount += int'(bus3.bubble);
    cyc();
    #1;
    chk("fz_f2", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd6);
    chk("fz_cnt_hold", 32'(u_lat3.r_cnt), 32'd2);
    bcount += int'(bus3.bubble);
    cyc();
    bus3.mem_ready = 1'b1;
    #1;
    chk("fz_c2", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd3);
    bcount += int'(bus3.bubble);
    cyc();
    bus3.mem_is_load = 1'b0;
    #1;
    chk("fz_c3", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd3);
    bcount += int'(bus3.bubble);
    cyc();
    #1;
    chk("fz_done", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd0);
    bcount += int'(bus3.bubble);
    chk("fz_bubbles", 32'(bcount), 32'd3);
`ifdef FWD_HAZARD_PERF_CNT_EN
    chk("perf_stall", bus3.stall_cycles, 32'd3);
    chk("perf_freeze", bus3.freeze_cycles, 32'd2);
`endif

    // Reset in the second cycle of a LOAD_LAT=3 stall aborts it.
    hazard3();
    #1 chk("rs_c1", 32'(bus3.stall), 32'd1);
    cyc();
    clear_ex3();
    RST = 1'b1;
    bus3.mem_is_load = 1'b1; bus3.mem_ready = 1'b0;
    #1 chk("rs_in_rst", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd0);
    cyc();
    RST = 1'b0;
    idle3();
    #1;
    chk("rs_after", 32'({bus3.freeze, bus3.stall, bus3.bubble}), 32'd0);
    chk("rs_cnt", 32'(u_lat3.r_cnt), 32'd0);
    cyc();
    #1 chk("rs_after2", 32'(bus3.stall), 32'd0);
`ifdef FWD_HAZARD_PERF_CNT_EN
    chk("perf_rst_clear", bus3.stall_cycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
